rx_cmd_sched: RTL and testbench

Command scheduler between the UART receive bridge and the ECS measurement datapath. Takes each validated 5-byte frame payload (Data1..Data5, strobed by RX_rdy), checks it, and decodes it as a command. It then updates the configuration registers or sequences the measurement engine through repeated start/done handshakes. Every accepted frame produces exactly one status byte on a request/acknowledge transmit interface.

---
 rtl/rx_cmd_sched.sv | 204 ++++++++++++++++++++
 tb/tb_rx_cmd_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_cmd_sched.sv
// Command scheduler: checks and decodes 5-byte frames from the UART bridge, writes
// configuration registers or sequences the measurement engine, and returns one status byte per frame.
module rx_cmd_sched #(
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RX_rdy,
   input  logic [7:0]  Data1,
   input  logic [7:0]  Data2,
   input  logic [7:0]  Data3,
   input  logic [7:0]  Data4,
   input  logic [7:0]  Data5,
   output logic        meas_start,
   input  logic        meas_done,
   output logic [7:0]  cfg_gain,
   output logic [7:0]  cfg_mode,
   output logic [15:0] cfg_freq,
   output logic        tx_req,
   output logic [7:0]  tx_byte,
   input  logic        tx_ack,
   output logic        busy,
   output logic [7:0]  err_cnt,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHECK  = 3'd1,
      LAUNCH = 3'd2,
      WAIT   = 3'd3,
      REPLY  = 3'd4
   } state_t;

   localparam logic [7:0] CMD_SET_CFG  = 8'h01;
   localparam logic [7:0] CMD_SET_FREQ = 8'h02;
   localparam logic [7:0] CMD_START    = 8'h04;
   localparam logic [7:0] CMD_STOP     = 8'h08;

   localparam logic [7:0] RSP_OK       = 8'h55;
   localparam logic [7:0] RSP_BAD_SUM  = 8'h5A;
   localparam logic [7:0] RSP_BAD_CMD  = 8'h5B;
   localparam logic [7:0] RSP_TIMEOUT  = 8'h5C;
   localparam logic [7:0] RSP_DONE     = 8'h5D;
   localparam logic [7:0] RSP_STOPPED  = 8'h5E;

   localparam logic [16:0] TO_LAST = 17'(TIMEOUT_CYC) - 17'd1;

   state_t      state;
   logic [7:0]  f_cmd;
   logic [7:0]  f_arg1;
   logic [7:0]  f_arg2;
   logic [7:0]  f_arg3;
   logic [7:0]  f_sum;
   logic [7:0]  run_cnt;
   logic [15:0] to_cnt;

   logic [7:0]  rx_sum;
   logic [7:0]  f_calc;
   logic        rx_stop;
   logic        f_sum_ok;
   logic        cmd_known;
   logic        to_hit;
   logic        stop_take;
   logic        drop_ev;
   logic        fail_ev;
   logic [1:0]  err_inc;
   logic [8:0]  err_next;

   assign rx_sum    = Data1 + Data2 + Data3 + Data4;
   assign f_calc    = f_cmd + f_arg1 + f_arg2 + f_arg3;
   assign rx_stop   = RX_rdy && (rx_sum == Data5) && (Data1 == CMD_STOP);
   assign f_sum_ok  = (f_calc == f_sum);
   assign cmd_known = (f_cmd == CMD_SET_CFG) || (f_cmd == CMD_SET_FREQ) || (f_cmd == CMD_START);
   // Counter is compared one step ahead so REPLY lands TIMEOUT_CYC cycles after meas_start.
   assign to_hit    = (({1'b0, to_cnt} + 17'd1) >= TO_LAST);

   // meas_done outranks STOP, so a STOP coinciding with done is treated as a dropped frame.
   assign stop_take = (state == WAIT) && !meas_done && rx_stop;
   assign drop_ev   = RX_rdy && (state != IDLE) && !stop_take;
   assign fail_ev   = ((state == CHECK) && (!f_sum_ok || !cmd_known)) ||
                      ((state == WAIT) && !meas_done && !rx_stop && to_hit);
   assign err_inc   = {1'b0, drop_ev} + {1'b0, fail_ev};
   assign err_next  = {1'b0, err_cnt} + {7'd0, err_inc};

   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_cnt <= 8'h00;
      end else begin
         err_cnt <= err_next[8] ? 8'hFF : err_next[7:0];
      end
   end

   // tx_req/tx_byte form a req/ack pair: once tx_req rises, tx_byte is frozen until tx_ack is
   // sampled high; tx_req drops on that same edge and tx_ack seen with tx_req low has no effect.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         meas_start <= 1'b0;
         tx_req     <= 1'b0;
         tx_byte    <= 8'h00;
         cfg_gain   <= 8'h00;
         cfg_mode   <= 8'h00;
         cfg_freq   <= 16'h0000;
         f_cmd      <= 8'h00;
         f_arg1     <= 8'h00;
         f_arg2     <= 8'h00;
         f_arg3     <= 8'h00;
         f_sum      <= 8'h00;
         run_cnt    <= 8'h00;
         to_cnt     <= 16'h0000;
      end else begin
         meas_start <= 1'b0;
         case (state)
            IDLE: begin
               if (RX_rdy) begin
                  f_cmd  <= Data1;
                  f_arg1 <= Data2;
                  f_arg2 <= Data3;
                  f_arg3 <= Data4;
                  f_sum  <= Data5;
                  busy   <= 1'b1;
                  state  <= CHECK;
               end
            end
            CHECK: begin
               if (!f_sum_ok) begin
                  tx_byte <= RSP_BAD_SUM;
                  tx_req  <= 1'b1;
                  state   <= REPLY;
               end else begin
                  case (f_cmd)
                     CMD_SET_CFG: begin
                        cfg_gain <= f_arg1;
                        cfg_mode <= f_arg2;
                        tx_byte  <= RSP_OK;
                        tx_req   <= 1'b1;
                        state    <= REPLY;
                     end
                     CMD_SET_FREQ: begin
                        cfg_freq <= {f_arg1, f_arg2};
                        tx_byte  <= RSP_OK;
                        tx_req   <= 1'b1;
                        state    <= REPLY;
                     end
                     CMD_START: begin
                        run_cnt    <= (f_arg1 == 8'h00) ? 8'h01 : f_arg1;
                        meas_start <= 1'b1;
                        state      <= LAUNCH;
                     end
                     default: begin
                        tx_byte <= RSP_BAD_CMD;
                        tx_req  <= 1'b1;
                        state   <= REPLY;
                     end
                  endcase
               end
            end
            LAUNCH: begin
               to_cnt <= 16'h0000;
               state  <= WAIT;
            end
            WAIT: begin
               to_cnt <= to_cnt + 16'd1;
               if (meas_done) begin
                  if (run_cnt == 8'h01) begin
                     tx_byte <= RSP_DONE;
                     tx_req  <= 1'b1;
                     state   <= REPLY;
                  end else begin
                     run_cnt    <= run_cnt - 8'h01;
                     meas_start <= 1'b1;
                     state      <= LAUNCH;
                  end
               end else if (rx_stop) begin
                  tx_byte <= RSP_STOPPED;
                  tx_req  <= 1'b1;
                  state   <= REPLY;
               end else if (to_hit) begin
                  tx_byte <= RSP_TIMEOUT;
                  tx_req  <= 1'b1;
                  state   <= REPLY;
               end
            end
            REPLY: begin
               if (tx_ack) begin
                  tx_req <= 1'b0;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               tx_req <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rx_cmd_sched.sv
// Bench for rx_cmd_sched: a vector table, hand-written corner sequences and random frames
// checked against a transaction-level model of the command rules.
module tb_rx_cmd_sched;

   localparam int TO = 100;

   logic        clk;
   logic        rst;
   logic        RX_rdy;
   logic [7:0]  Data1, Data2, Data3, Data4, Data5;
   logic        meas_start;
   logic        meas_done;
   logic [7:0]  cfg_gain;
   logic [7:0]  cfg_mode;
   logic [15:0] cfg_freq;
   logic        tx_req;
   logic [7:0]  tx_byte;
   logic        tx_ack;
   logic        busy;
   logic [7:0]  err_cnt;
   logic [2:0]  dbg_state;

   rx_cmd_sched #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .RX_rdy(RX_rdy),
      .Data1(Data1), .Data2(Data2), .Data3(Data3), .Data4(Data4), .Data5(Data5),
      .meas_start(meas_start), .meas_done(meas_done),
      .cfg_gain(cfg_gain), .cfg_mode(cfg_mode), .cfg_freq(cfg_freq),
      .tx_req(tx_req), .tx_byte(tx_byte), .tx_ack(tx_ack),
      .busy(busy), .err_cnt(err_cnt), .dbg_state(dbg_state)
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] exp_q[$];

   // model state
   int          m_err  = 0;
   logic [7:0]  m_gain = 8'h00;
   logic [7:0]  m_mode = 8'h00;
   logic [15:0] m_freq = 16'h0000;

   // measurement engine stand-in
   int start_cnt = 0;
   int done_cd   = 0;
   logic done_en;
   int   done_dly;

   typedef struct {
      logic [39:0] frame;
      logic [7:0]  code;
      int          starts;
      logic [7:0]  err;
      logic [7:0]  gain;
      logic [7:0]  mode;
      logic [15:0] freq;
   } vec_t;

   vec_t vecs[10];

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got time %0t required below 3000000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      meas_done = 1'b0;
      forever begin
         @(negedge clk);
         meas_done = 1'b0;
         if (!rst) begin
            done_cd = 0;
         end else begin
            if (done_cd > 0) begin
               done_cd--;
               if (done_cd == 0) meas_done = 1'b1;
            end
            if (meas_start) begin
               start_cnt++;
               if (done_en) done_cd = done_dly;
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
   endtask

   function automatic int sat_err(input int e, input int inc);
      return (e + inc > 255) ? 255 : e + inc;
   endfunction

   // Transaction-level rules: expected reply, number of measurements, register effects.
   task automatic model_frame(input logic [39:0] fr, output logic [7:0] code, output int starts);
      int d1, d2, d3, d4, d5;
      d1 = int'(fr[39:32]); d2 = int'(fr[31:24]); d3 = int'(fr[23:16]);
      d4 = int'(fr[15:8]);  d5 = int'(fr[7:0]);
      starts = 0;
      if (((d1 + d2 + d3 + d4) % 256) != d5) begin
         code = 8'h5A; m_err = sat_err(m_err, 1);
      end else if (d1 == 1) begin
         m_gain = 8'(d2); m_mode = 8'(d3); code = 8'h55;
      end else if (d1 == 2) begin
         m_freq = 16'(d2 * 256 + d3); code = 8'h55;
      end else if (d1 == 4) begin
         starts = (d2 == 0) ? 1 : d2; code = 8'h5D;
      end else begin
         code = 8'h5B; m_err = sat_err(m_err, 1);
      end
   endtask

   // driver tasks: all called and returning at a falling edge
   task automatic send_frame(input logic [39:0] fr);
      {Data1, Data2, Data3, Data4, Data5} = fr;
      RX_rdy = 1'b1;
      @(negedge clk);
      RX_rdy = 1'b0;
   endtask

   task automatic take_reply(input string name);
      int w;
      logic [7:0] e;
      w = 0;
      while (!tx_req && w < 2000) begin
         @(negedge clk);
         w++;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check({name, " code"}, {tx_req, tx_byte}, {1'b1, e});
      if (tx_req) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         check({name, " held"}, {tx_req, tx_byte}, {1'b1, e});
         tx_ack = 1'b1;
         @(negedge clk);
         tx_ack = 1'b0;
         check({name, " ack clears req/busy"}, {tx_req, busy}, 2'b00);
      end
   endtask

   task automatic run_frame(input string name, input logic [39:0] fr, input logic [7:0] code,
                            input int starts, input logic [7:0] e_err, input logic [7:0] e_gain,
                            input logic [7:0] e_mode, input logic [15:0] e_freq);
      int s0;
      s0 = start_cnt;
      exp_q.push_back(code);
      send_frame(fr);
      check({name, " busy N+1"}, {busy, tx_req}, 2'b10);
      @(negedge clk);
      if (starts == 0) check({name, " tx_req N+2"}, tx_req, 1);
      else check({name, " meas_start N+2"}, meas_start, 1);
      check({name, " cfg"}, {cfg_gain, cfg_mode, cfg_freq}, {e_gain, e_mode, e_freq});
      take_reply(name);
      check({name, " starts"}, start_cnt - s0, starts);
      check({name, " err_cnt"}, err_cnt, e_err);
   endtask

   task automatic run_model(input string name, input logic [39:0] fr);
      logic [7:0] code;
      int starts;
      model_frame(fr, code, starts);
      run_frame(name, fr, code, starts, 8'(m_err), m_gain, m_mode, m_freq);
   endtask

   initial begin
      int s0, w, seen;
      logic [7:0] d1, d2, d3, d4, d5;

      vecs[0] = '{40'h01_10_20_00_31, 8'h55, 0, 8'd0, 8'h10, 8'h20, 16'h0000};
      vecs[1] = '{40'h04_02_01_00_07, 8'h5D, 2, 8'd0, 8'h10, 8'h20, 16'h0000};
      vecs[2] = '{40'h04_02_01_00_08, 8'h5A, 0, 8'd1, 8'h10, 8'h20, 16'h0000};
      vecs[3] = '{40'h03_00_00_00_03, 8'h5B, 0, 8'd2, 8'h10, 8'h20, 16'h0000};
      vecs[4] = '{40'h02_12_34_00_48, 8'h55, 0, 8'd2, 8'h10, 8'h20, 16'h1234};
      vecs[5] = '{40'h08_00_00_00_08, 8'h5B, 0, 8'd3, 8'h10, 8'h20, 16'h1234};
      vecs[6] = '{40'h04_00_00_00_04, 8'h5D, 1, 8'd3, 8'h10, 8'h20, 16'h1234};
      vecs[7] = '{40'h01_AB_CD_00_79, 8'h55, 0, 8'd3, 8'hAB, 8'hCD, 16'h1234};
      vecs[8] = '{40'h01_00_00_00_00, 8'h5A, 0, 8'd4, 8'hAB, 8'hCD, 16'h1234};
      vecs[9] = '{40'h02_FF_FF_01_01, 8'h55, 0, 8'd4, 8'hAB, 8'hCD, 16'hFFFF};

      rst = 1'b1; RX_rdy = 1'b0; tx_ack = 1'b0;
      {Data1, Data2, Data3, Data4, Data5} = 40'h0;
      done_en = 1'b1; done_dly = 5;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset outputs", {busy, meas_start, tx_req, tx_byte, err_cnt, cfg_gain, cfg_mode, cfg_freq}, 64'h0);
      rst = 1'b1;
      @(negedge clk);
      check("after reset idle", {busy, tx_req, meas_start}, 3'b000);

      // vector table
      for (int i = 0; i < 10; i++)
         run_frame($sformatf("vec%0d", i), vecs[i].frame, vecs[i].code, vecs[i].starts,
                   vecs[i].err, vecs[i].gain, vecs[i].mode, vecs[i].freq);
      m_err = 4; m_gain = 8'hAB; m_mode = 8'hCD; m_freq = 16'hFFFF;

      // random frames against the model
      for (int i = 0; i < 40; i++) begin
         d2 = 8'($urandom_range(0, 255));
         d3 = 8'($urandom_range(0, 255));
         d4 = 8'($urandom_range(0, 255));
         case ($urandom_range(0, 4))
            0: d1 = 8'h01;
            1: d1 = 8'h02;
            2: begin d1 = 8'h04; d2 = 8'($urandom_range(0, 3)); end
            3: d1 = 8'h08;
            default: d1 = 8'($urandom_range(0, 255));
         endcase
         d5 = d1 + d2 + d3 + d4;
         if ($urandom_range(0, 7) == 0) d5 = d5 + 8'($urandom_range(1, 255));
         done_dly = $urandom_range(1, 8);
         run_model($sformatf("rand%0d", i), {d1, d2, d3, d4, d5});
      end

      // STOP during WAIT, stray ack, frame dropped during REPLY
      done_en = 1'b0;
      s0 = start_cnt;
      send_frame(40'h04_03_00_00_07);
      @(negedge clk);
      check("stop meas_start", meas_start, 1);
      repeat (3) @(negedge clk);
      tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("stray ack ignored", {busy, tx_req}, 2'b10);
      exp_q.push_back(8'h5E);
      send_frame(40'h08_00_00_00_08);
      check("stop reply up", {tx_req, tx_byte}, {1'b1, 8'h5E});
      send_frame(40'h01_77_66_00_DE);
      m_err = sat_err(m_err, 1);
      take_reply("stop");
      repeat (20) @(negedge clk);
      check("stop no more starts", start_cnt - s0, 1);
      check("drop cfg unchanged", {cfg_gain, cfg_mode, cfg_freq}, {m_gain, m_mode, m_freq});
      check("drop err_cnt", err_cnt, m_err);

      // last done coinciding with STOP
      done_en = 1'b1; done_dly = 6;
      send_frame(40'h04_01_00_00_05);
      @(negedge clk);
      check("coin meas_start", meas_start, 1);
      repeat (6) @(negedge clk);
      exp_q.push_back(8'h5D);
      send_frame(40'h08_00_00_00_08);
      m_err = sat_err(m_err, 1);
      take_reply("coin");
      check("coin err_cnt", err_cnt, m_err);

      // timeout
      done_en = 1'b0;
      s0 = start_cnt;
      send_frame(40'h04_01_00_00_05);
      @(negedge clk);
      check("to meas_start", meas_start, 1);
      w = 0;
      while (!tx_req && w < 500) begin
         @(negedge clk);
         w++;
      end
      check("to latency", w, TO);
      exp_q.push_back(8'h5C);
      m_err = sat_err(m_err, 1);
      take_reply("to");
      check("to err_cnt", err_cnt, m_err);
      check("to starts", start_cnt - s0, 1);

      // err_cnt saturation
      for (int i = 0; i < 260; i++) begin
         m_err = sat_err(m_err, 1);
         run_frame("sat", 40'h01_00_00_00_00, 8'h5A, 0, 8'(m_err), m_gain, m_mode, m_freq);
      end
      check("sat err_cnt", err_cnt, 8'hFF);

      // reset in the middle of WAIT
      send_frame(40'h04_01_00_00_05);
      repeat (10) @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid reset outputs", {busy, meas_start, tx_req, tx_byte, err_cnt, cfg_gain, cfg_mode, cfg_freq}, 64'h0);
      @(negedge clk);
      rst = 1'b1;
      m_err = 0; m_gain = 8'h00; m_mode = 8'h00; m_freq = 16'h0000;
      seen = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (tx_req) seen++;
      end
      check("mid reset no tx_req", seen, 0);

      done_en = 1'b1; done_dly = 5;
      run_model("post reset", 40'h01_10_20_00_31);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
